calc_key_sequencer: RTL and testbench

- Synchronous controller between the 4x4 keypad decoder and the combinational calculator datapath.
- Collects two decimal operands (up to 2 digits each) and one operator from single-cycle key pulses, then drives the datapath operand/opcode inputs for one execute cycle.
- Captures the result as sign + magnitude and holds it for the display.
- Owns the datapath: the datapath is never driven from the keypad directly.

---
 rtl/calc_key_sequencer_if.sv | 27 ++
 rtl/calc_key_sequencer.sv | 157 +++++++++++++++
 tb/tb_calc_key_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/calc_key_sequencer_if.sv
// Keypad-side, datapath-side and display-side signals of the calculator
// key sequencer. The sequencer uses the master view; the keypad decoder,
// the combinational datapath and the display together form the slave view.
interface calc_key_sequencer_if;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [31:0] calc_answer;
    logic [6:0]  calc_in1;
    logic [6:0]  calc_in2;
    logic [3:0]  calc_key;
    logic [13:0] disp_value;
    logic        result_neg;
    logic        result_valid;
    logic        busy;

    modport master (
        input  key_code, key_valid, calc_answer,
        output calc_in1, calc_in2, calc_key, disp_value,
               result_neg, result_valid, busy
    );

    modport slave (
        output key_code, key_valid, calc_answer,
        input  calc_in1, calc_in2, calc_key, disp_value,
               result_neg, result_valid, busy
    );
endinterface

// File: rtl/calc_key_sequencer.sv
// Calculator key sequencer: gathers two decimal operands and an operator
// from keypad pulses, presents them to the datapath for one execute cycle
// and holds the answer as sign + magnitude for the display.
module calc_key_sequencer #(
    parameter int         MAX_DIGITS = 2,
    parameter logic [3:0] KEY_ADD    = 4'd10,
    parameter logic [3:0] KEY_SUB    = 4'd11,
    parameter logic [3:0] KEY_MUL    = 4'd12,
    parameter logic [3:0] KEY_CLR    = 4'd13,
    parameter logic [3:0] KEY_BKSP   = 4'd14,
    parameter logic [3:0] KEY_EQ     = 4'd15
) (
    input  logic                 clk,
    input  logic                 reset,
    calc_key_sequencer_if.master bus
);
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DIGITS);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {ENTER_A, ENTER_B, EXEC, RESULT} state_t;

    state_t        state, state_n;
    logic [6:0]    op_a, op_a_n, op_b, op_b_n;
    logic [CW-1:0] cnt_a, cnt_a_n, cnt_b, cnt_b_n;
    logic [3:0]    op_sel, op_sel_n;
    logic [13:0]   res_mag, res_mag_n;
    logic          res_neg, res_neg_n;

    logic          is_digit, is_op, is_clr;
    logic          neg_now;
    logic [31:0]   neg_ans;
    logic [6:0]    digit;

    assign digit    = {3'b000, bus.key_code};
    assign is_digit = bus.key_valid && (bus.key_code <= 4'd9);
    assign is_op    = bus.key_valid && (bus.key_code == KEY_ADD ||
                                        bus.key_code == KEY_SUB ||
                                        bus.key_code == KEY_MUL);
    assign is_clr   = bus.key_valid && (bus.key_code == KEY_CLR);

    // Sign comes from the operands, not the datapath's own flag, so the
    // magnitude is the two's complement of the answer when B > A on a subtract.
    assign neg_now  = (op_sel == KEY_SUB) && (op_b > op_a);
    assign neg_ans  = 32'd0 - bus.calc_answer;

    // State and operand registers; reset wins over everything, including EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ENTER_A;
            op_a    <= '0;
            op_b    <= '0;
            cnt_a   <= '0;
            cnt_b   <= '0;
            op_sel  <= '0;
            res_mag <= '0;
            res_neg <= 1'b0;
        end else begin
            state   <= state_n;
            op_a    <= op_a_n;
            op_b    <= op_b_n;
            cnt_a   <= cnt_a_n;
            cnt_b   <= cnt_b_n;
            op_sel  <= op_sel_n;
            res_mag <= res_mag_n;
            res_neg <= res_neg_n;
        end
    end

    // Key decoding and next-state logic; unlisted keys leave everything as is.
    always_comb begin
        state_n   = state;
        op_a_n    = op_a;
        op_b_n    = op_b;
        cnt_a_n   = cnt_a;
        cnt_b_n   = cnt_b;
        op_sel_n  = op_sel;
        res_mag_n = res_mag;
        res_neg_n = res_neg;

        if (is_clr && state != EXEC) begin
            state_n   = ENTER_A;
            op_a_n    = '0;
            op_b_n    = '0;
            cnt_a_n   = '0;
            cnt_b_n   = '0;
            op_sel_n  = '0;
            res_mag_n = '0;
            res_neg_n = 1'b0;
        end else begin
            case (state)
                ENTER_A: begin
                    if (is_digit && cnt_a < CNT_MAX) begin
                        op_a_n  = op_a * 7'd10 + digit;
                        cnt_a_n = cnt_a + CNT_ONE;
                    end else if (is_op && cnt_a != '0) begin
                        op_sel_n = bus.key_code;
                        state_n  = ENTER_B;
                    end else if (bus.key_valid && bus.key_code == KEY_BKSP) begin
                        op_a_n  = '0;
                        cnt_a_n = '0;
                    end
                end
                ENTER_B: begin
                    if (is_digit && cnt_b < CNT_MAX) begin
                        op_b_n  = op_b * 7'd10 + digit;
                        cnt_b_n = cnt_b + CNT_ONE;
                    end else if (is_op && cnt_b == '0) begin
                        op_sel_n = bus.key_code;
                    end else if (bus.key_valid && bus.key_code == KEY_BKSP) begin
                        if (cnt_b != '0) begin
                            op_b_n  = '0;
                            cnt_b_n = '0;
                        end else begin
                            state_n = ENTER_A;
                        end
                    end else if (bus.key_valid && bus.key_code == KEY_EQ && cnt_b != '0) begin
                        state_n = EXEC;
                    end
                end
                EXEC: begin
                    res_neg_n = neg_now;
                    res_mag_n = neg_now ? neg_ans[13:0] : bus.calc_answer[13:0];
                    state_n   = RESULT;
                end
                RESULT: begin
                    if (is_digit) begin
                        state_n   = ENTER_A;
                        op_a_n    = digit;
                        cnt_a_n   = CNT_ONE;
                        op_b_n    = '0;
                        cnt_b_n   = '0;
                        op_sel_n  = '0;
                        res_mag_n = '0;
                        res_neg_n = 1'b0;
                    end
                end
                default: state_n = ENTER_A;
            endcase
        end
    end

    // Datapath drive and display selection, all from registered state.
    always_comb begin
        bus.calc_in1     = op_a;
        bus.calc_in2     = op_b;
        bus.calc_key     = (state == EXEC) ? op_sel : KEY_CLR;
        bus.busy         = (state == EXEC);
        bus.result_valid = (state == RESULT);
        bus.result_neg   = res_neg && (state == RESULT);
        case (state)
            ENTER_A: bus.disp_value = {7'd0, op_a};
            ENTER_B: bus.disp_value = {7'd0, op_b};
            default: bus.disp_value = res_mag;
        endcase
    end
endmodule

// File: tb/tb_calc_key_sequencer.sv
// Directed bench for calc_key_sequencer with a scoreboard: stimulus queues
// expected execute snapshots, results and state probes; a monitor on the
// falling edge pops and compares them as the DUT presents them.
module tb_calc_key_sequencer;
    localparam int KA = 10, KB = 11, KC = 12, KCLR = 13, KBK = 14, KEQ = 15;

    typedef struct { logic [3:0] key; logic [6:0] in1; logic [6:0] in2; } exec_t;
    typedef struct { int cyc; logic [13:0] mag; logic neg; } res_t;
    typedef struct { int cyc; string name; logic [34:0] v; } probe_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    logic done = 1'b0;

    calc_key_sequencer_if bus();

    calc_key_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Combinational datapath model: add/sub/mul on zero-extended operands.
    always_comb begin
        case (bus.calc_key)
            4'd10:   bus.calc_answer = {25'd0, bus.calc_in1} + {25'd0, bus.calc_in2};
            4'd11:   bus.calc_answer = {25'd0, bus.calc_in1} - {25'd0, bus.calc_in2};
            4'd12:   bus.calc_answer = {25'd0, bus.calc_in1} * {25'd0, bus.calc_in2};
            default: bus.calc_answer = 32'd0;
        endcase
    end

    exec_t  xq[$];
    res_t   rq[$];
    probe_t pq[$];

    int     total = 0;
    int     bad = 0;
    logic   prev_rv = 1'b0;
    exec_t  e;
    res_t   r;
    probe_t p;
    logic [34:0] got;

    // Monitor: compares whatever the DUT presents against the queued expectations.
    always @(negedge clk) begin
        if (bus.busy) begin
            total++;
            if (xq.size() == 0) begin
                bad++;
                $display("FAIL exec_unexpected: busy=1 at cycle %0d with nothing pending", cyc);
            end else begin
                e = xq.pop_front();
                if ({bus.calc_key, bus.calc_in1, bus.calc_in2} !== {e.key, e.in1, e.in2}) begin
                    bad++;
                    $display("FAIL exec_inputs: got key=%0d in1=%0d in2=%0d expected key=%0d in1=%0d in2=%0d",
                             bus.calc_key, bus.calc_in1, bus.calc_in2, e.key, e.in1, e.in2);
                end
            end
        end
        if (bus.result_valid && !prev_rv) begin
            total++;
            if (rq.size() == 0) begin
                bad++;
                $display("FAIL result_unexpected: result_valid rose at cycle %0d", cyc);
            end else begin
                r = rq.pop_front();
                if (bus.disp_value !== r.mag || bus.result_neg !== r.neg || cyc != r.cyc) begin
                    bad++;
                    $display("FAIL result: got mag=%0d neg=%0b cycle=%0d expected mag=%0d neg=%0b cycle=%0d",
                             bus.disp_value, bus.result_neg, cyc, r.mag, r.neg, r.cyc);
                end
            end
        end
        prev_rv = bus.result_valid;
        if (pq.size() > 0 && pq[0].cyc == cyc) begin
            p = pq.pop_front();
            got = {bus.disp_value, bus.calc_key, bus.calc_in1, bus.calc_in2,
                   bus.result_valid, bus.result_neg, bus.busy};
            total++;
            if (got !== p.v) begin
                bad++;
                $display("FAIL %s: got disp=%0d key=%0d in1=%0d in2=%0d rv=%0b neg=%0b busy=%0b expected disp=%0d key=%0d in1=%0d in2=%0d rv=%0b neg=%0b busy=%0b",
                         p.name, got[34:21], got[20:17], got[16:10], got[9:3], got[2], got[1], got[0],
                         p.v[34:21], p.v[20:17], p.v[16:10], p.v[9:3], p.v[2], p.v[1], p.v[0]);
            end
        end
        if (done) begin
            total++;
            if (xq.size() != 0 || rq.size() != 0 || pq.size() != 0) begin
                bad++;
                $display("FAIL drained: left exec=%0d result=%0d probe=%0d expected 0 0 0",
                         xq.size(), rq.size(), pq.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // All stimulus tasks are entered just after a falling edge.
    task automatic press(input int k);
        bus.key_code  = 4'(k);
        bus.key_valid = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b0;
    endtask

    task automatic probe(input string nm, input int disp, input int ck, input int in1,
                         input int in2, input int rv, input int neg, input int bsy);
        probe_t q;
        q.cyc  = cyc + 1;
        q.name = nm;
        q.v    = {14'(disp), 4'(ck), 7'(in1), 7'(in2), 1'(rv), 1'(neg), 1'(bsy)};
        pq.push_back(q);
        @(negedge clk);
    endtask

    task automatic eq(input int ck, input int in1, input int in2, input int mag,
                      input int neg, input bit expect_result);
        exec_t x;
        res_t  y;
        x.key = 4'(ck);
        x.in1 = 7'(in1);
        x.in2 = 7'(in2);
        xq.push_back(x);
        if (expect_result) begin
            y.cyc = cyc + 2;
            y.mag = 14'(mag);
            y.neg = 1'(neg);
            rq.push_back(y);
        end
        press(KEQ);
    endtask

    initial begin
        reset         = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        probe("reset_state", 0, KCLR, 0, 0, 0, 0, 0);

        press(KA);
        probe("op_without_digits", 0, KCLR, 0, 0, 0, 0, 0);
        press(1); press(2);
        probe("enter_a_12", 12, KCLR, 12, 0, 0, 0, 0);
        press(KA);
        probe("enter_b_shown", 0, KCLR, 12, 0, 0, 0, 0);
        press(3); press(4);
        eq(KA, 12, 34, 46, 0, 1'b1);
        @(negedge clk);
        probe("add_result", 46, KCLR, 12, 34, 1, 0, 0);

        press(5); press(KB); press(2); press(0);
        eq(KB, 5, 20, 15, 1, 1'b1);
        @(negedge clk);
        probe("sub_negative", 15, KCLR, 5, 20, 1, 1, 0);
        press(2); press(0); press(KB); press(5);
        eq(KB, 20, 5, 15, 0, 1'b1);
        @(negedge clk);

        press(9); press(9); press(9);
        probe("third_digit_ignored", 99, KCLR, 99, 0, 0, 0, 0);
        press(KC); press(9); press(9);
        eq(KC, 99, 99, 9801, 0, 1'b1);
        @(negedge clk);
        press(7);
        probe("digit_after_result", 7, KCLR, 7, 0, 0, 0, 0);

        press(KCLR);
        press(3); press(KA); press(KBK);
        probe("bksp_back_to_a", 3, KCLR, 3, 0, 0, 0, 0);
        press(4);
        probe("op_a_kept", 34, KCLR, 34, 0, 0, 0, 0);

        press(KCLR);
        press(4); press(KA); press(KEQ);
        probe("eq_without_b", 0, KCLR, 4, 0, 0, 0, 0);
        press(KB); press(2);
        eq(KB, 4, 2, 2, 0, 1'b1);
        @(negedge clk);

        press(6); press(KC); press(7);
        eq(KC, 6, 7, 42, 0, 1'b1);
        press(5);
        probe("key_dropped_in_exec", 42, KCLR, 6, 7, 1, 0, 0);

        press(8); press(KA); press(5);
        press(KCLR);
        probe("clr_in_enter_b", 0, KCLR, 0, 0, 0, 0, 0);

        press(1); press(KA); press(1);
        eq(KA, 1, 1, 0, 0, 1'b0);
        reset         = 1'b1;
        bus.key_code  = 4'd3;
        bus.key_valid = 1'b1;
        @(negedge clk);
        reset         = 1'b0;
        bus.key_valid = 1'b0;
        probe("reset_in_exec", 0, KCLR, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        probe("no_late_result", 0, KCLR, 0, 0, 0, 0, 0);

        done = 1'b1;
    end
endmodule
